// File: rtl/nn_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_lut_pkg
// Description : Shared widths, FSM state encoding and the input index split
//               for the activation-table segment fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_lut_pkg;

    localparam int DATA_W      = 8;
    localparam int FRAC_W      = 4;
    localparam int ADDR_W      = DATA_W - FRAC_W;
    localparam int TABLE_DEPTH = (2 ** ADDR_W) + 1;
    // Table port address carries one extra bit so entry 2**ADDR_W is reachable
    localparam int PORT_AW     = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_CAP  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [FRAC_W-1:0] frac;
    } split_t;

    // Integer part re-biased to offset binary (flip the sign bit) so the most
    // negative input lands on entry 0; fractional bits pass straight through.
    function automatic split_t lut_split(input logic [DATA_W-1:0] x);
        split_t s;
        s.idx  = x[DATA_W-1 -: ADDR_W] ^ {1'b1, {(ADDR_W-1){1'b0}}};
        s.frac = x[FRAC_W-1:0];
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_lut_table_ram.sv
`default_nettype none
// ============================================================================
// Module      : nn_lut_table_ram
// Description : Single-port synchronous breakpoint RAM with registered read
//               data. A write takes the port; the read register then holds.
//               Addresses beyond the last entry are ignored. No reset.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_lut_table_ram
    import nn_lut_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int AW    = PORT_AW,
    parameter int DEPTH = TABLE_DEPTH
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [DW-1:0] r_rdata;

    // Write has priority on the shared port; read data only updates on reads
    always_ff @(posedge clk) begin
        if (i_we) begin
            if (i_addr <= c_last_addr) begin
                r_mem[i_addr] <= i_wdata;
            end
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/nn_lut_segment_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : nn_lut_segment_fetcher
// Description : Splits a signed Q4.4 activation into table index and
//               fractional remainder, fetches the two bracketing breakpoints
//               from the table RAM and presents them to the interpolator
//               over valid/ready. Also exposes the table-load write port.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_lut_segment_fetcher
    import nn_lut_pkg::*;
#(
    parameter int DATA_W = nn_lut_pkg::DATA_W,
    parameter int FRAC_W = nn_lut_pkg::FRAC_W,
    parameter int ADDR_W = nn_lut_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_base,
    output logic [DATA_W-1:0] out_next,
    output logic [DATA_W-1:0] out_remaining,
    output logic              busy
);

    state_t              r_state;
    state_t              w_state_next;
    split_t              w_split;
    logic [ADDR_W-1:0]   r_idx;
    logic [FRAC_W-1:0]   r_frac;
    logic [DATA_W-1:0]   r_base;
    logic [DATA_W-1:0]   r_next;
    logic [DATA_W-1:0]   r_rem;
    logic                w_latch;
    logic                w_cap_base;
    logic                w_cap_next;
    logic                w_rd_en;
    logic [ADDR_W:0]     w_rd_addr;
    logic [ADDR_W:0]     w_idx_ext;
    logic [ADDR_W:0]     w_ram_addr;
    logic [DATA_W-1:0]   w_ram_rdata;

    assign w_split   = lut_split(in_x);
    assign w_idx_ext = {1'b0, r_idx};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and datapath strobes; a write in RD0/RD1 stalls the fetch
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_cap_base   = 1'b0;
        w_cap_next   = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_addr    = '0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_RD0;
                end
            end
            ST_RD0: begin
                if (!wr_en) begin
                    w_rd_en      = 1'b1;
                    w_rd_addr    = w_idx_ext;
                    w_state_next = ST_RD1;
                end
            end
            ST_RD1: begin
                if (!wr_en) begin
                    w_cap_base   = 1'b1;
                    w_rd_en      = 1'b1;
                    w_rd_addr    = w_idx_ext + {{ADDR_W{1'b0}}, 1'b1};
                    w_state_next = ST_CAP;
                end
            end
            ST_CAP: begin
                w_cap_next   = 1'b1;
                w_state_next = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Input latch and output holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_frac <= '0;
            r_base <= '0;
            r_next <= '0;
            r_rem  <= '0;
        end else begin
            if (w_latch) begin
                r_idx  <= w_split.idx;
                r_frac <= w_split.frac;
            end
            if (w_cap_base) begin
                r_base <= w_ram_rdata;
            end
            if (w_cap_next) begin
                r_next <= w_ram_rdata;
                r_rem  <= {{(DATA_W-FRAC_W){1'b0}}, r_frac};
            end
        end
    end

    // The table-load port owns the RAM address whenever it writes
    assign w_ram_addr = wr_en ? wr_addr : w_rd_addr;

    nn_lut_table_ram #(
        .DW    (DATA_W),
        .AW    (ADDR_W + 1),
        .DEPTH ((2 ** ADDR_W) + 1)
    ) u_table_ram (
        .clk     (clk),
        .i_we    (wr_en),
        .i_re    (w_rd_en),
        .i_addr  (w_ram_addr),
        .i_wdata (wr_data),
        .o_rdata (w_ram_rdata)
    );

    assign in_ready      = (r_state == ST_IDLE) && !rst;
    assign out_valid     = (r_state == ST_OUT) && !rst;
    assign busy          = (r_state != ST_IDLE) && !rst;
    assign out_base      = r_base;
    assign out_next      = r_next;
    assign out_remaining = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_nn_lut_segment_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_lut_segment_fetcher
// Description : Directed self-checking bench for nn_lut_segment_fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_lut_segment_fetcher;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_base;
    logic [7:0] out_next;
    logic [7:0] out_remaining;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    nn_lut_segment_fetcher dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_base      (out_base),
        .out_next      (out_next),
        .out_remaining (out_remaining),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All drive/sample happens on the falling edge
    task automatic write_entry(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Returns at the falling edge right after the accept edge
    task automatic send(input logic [7:0] x);
        check_eq("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_x     = x;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic xact(input logic [7:0] x, input logic [7:0] eb,
                        input logic [7:0] en, input logic [7:0] er);
        int lat;
        out_ready = 1'b1;
        send(x);
        check_eq("busy_rd0", {31'd0, busy}, 32'd1);
        wait_valid(0, lat);
        check_eq("latency", lat, 32'd3);
        check_eq("base", {24'd0, out_base}, {24'd0, eb});
        check_eq("next", {24'd0, out_next}, {24'd0, en});
        check_eq("remaining", {24'd0, out_remaining}, {24'd0, er});
        @(negedge clk);
        check_eq("in_ready_after", {31'd0, in_ready}, 32'd1);
        check_eq("out_valid_after", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [7:0] d;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        in_valid = 1'b0; in_x = '0; out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_outs", {8'd0, out_base, out_next, out_remaining}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Table e[i] = 8*i - 64
        for (int i = 0; i <= 16; i++) begin
            d = 8'(8 * i - 64);
            write_entry(5'(i), d);
        end

        // 1: mid-range zero input
        xact(8'h00, 8'h00, 8'h08, 8'h00);
        // 2: top index reaches entry 16; most negative input hits entry 0
        xact(8'h7F, 8'h38, 8'h40, 8'h0F);
        xact(8'h80, 8'hC0, 8'hC8, 8'h00);

        // 3: backpressure holds outputs
        out_ready = 1'b0;
        send(8'h1A);
        wait_valid(0, lat);
        check_eq("bp_latency", lat, 32'd3);
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("bp_data", {8'd0, out_base, out_next, out_remaining}, 32'h0008100A);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_done_valid", {31'd0, out_valid}, 32'd0);
        check_eq("bp_done_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check_eq("bp_single_xfer", {31'd0, out_valid}, 32'd0);

        // 4: writes stall RD0 and RD1; fetch sees the new entry 9
        send(8'h1A);
        write_entry(5'd9, 8'h55);   // RD0 stalled
        @(negedge clk);             // RD0 reads
        write_entry(5'd9, 8'h55);   // RD1 stalled
        wait_valid(3, lat);
        check_eq("stall_latency", lat, 32'd5);
        check_eq("stall_base", {24'd0, out_base}, 32'h55);
        check_eq("stall_next", {24'd0, out_next}, 32'h10);
        check_eq("stall_rem", {24'd0, out_remaining}, 32'h0A);
        @(negedge clk);
        write_entry(5'd9, 8'h08);   // restore

        // 5: out-of-range write is ignored
        write_entry(5'd20, 8'h7F);
        xact(8'h7F, 8'h38, 8'h40, 8'h0F);

        // 6: reset during CAP drops the transaction
        out_ready = 1'b1;
        send(8'h1A);                // now RD0
        @(negedge clk);             // RD1
        @(negedge clk);             // CAP
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);
        end
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("post_rst_base", {24'd0, out_base}, 32'h0);
        xact(8'h00, 8'h00, 8'h08, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
